// File: rtl/calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer
//   Keypad-to-datapath controller for the BCD calculator. It turns debounced
//   key strobes into operand-memory controls and the ALU operation code. Entry
//   runs op1 -> operator -> op2 -> '=' -> ALU wait -> result display.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   key_valid    in   one-cycle strobe, key_code valid
//   key_code     in   [3:0] 0-9 digit, C clear, D add, E sub, F equals
//   key_ready    out  key can be accepted this cycle
//   is_num       out  one-cycle pulse: store num_val into selected operand
//   num_val      out  [3:0] BCD digit, valid with is_num
//   is_op1       out  operand 1 selected for entry
//   is_op2       out  operand 2 selected for entry
//   op_val       out  [3:0] ALU op (D add, E sub)
//   op_clr       out  one-cycle pulse: clear both operand memories
//   digit_cnt    out  [2:0] digits entered into current operand
//   disp_sel     out  [1:0] 00 op1, 01 op2, 10 result
//   result_valid out  result stable and displayable
// -----------------------------------------------------------------------------
module calc_key_sequencer #(
  parameter int MAX_DIGITS = 4,
  parameter int ALU_LAT    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       is_num,
  output logic [3:0] num_val,
  output logic       is_op1,
  output logic       is_op2,
  output logic [3:0] op_val,
  output logic       op_clr,
  output logic [2:0] digit_cnt,
  output logic [1:0] disp_sel,
  output logic       result_valid
);

  localparam int WAIT_W = $clog2(ALU_LAT + 2);

  localparam logic [3:0] KEY_CLR = 4'b1100;
  localparam logic [3:0] KEY_ADD = 4'b1101;
  localparam logic [3:0] KEY_SUB = 4'b1110;
  localparam logic [3:0] KEY_EQ  = 4'b1111;

  typedef enum logic [1:0] {
    ST_OP1  = 2'd0,
    ST_OP2  = 2'd1,
    ST_CALC = 2'd2,
    ST_SHOW = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              key_ready_q, key_ready_d;
  logic              is_num_q, is_num_d;
  logic [3:0]        num_val_q, num_val_d;
  logic              is_op1_q, is_op1_d;
  logic              is_op2_q, is_op2_d;
  logic [3:0]        op_val_q, op_val_d;
  logic              op_clr_q, op_clr_d;
  logic [2:0]        digit_cnt_q, digit_cnt_d;
  logic [1:0]        disp_sel_q, disp_sel_d;
  logic              result_valid_q, result_valid_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Key decode. key_ready_q is already low in CALC, so "accepted" alone
  // filters out keys pressed while the ALU is busy.
  logic accepted;
  logic key_digit;
  logic key_clr;
  logic key_arith;
  logic key_eq;
  logic entry_state;

  assign accepted    = key_valid & key_ready_q;
  assign key_digit   = accepted & (key_code <= 4'd9);
  assign key_clr     = accepted & (key_code == KEY_CLR);
  assign key_arith   = accepted & ((key_code == KEY_ADD) | (key_code == KEY_SUB));
  assign key_eq      = accepted & (key_code == KEY_EQ);
  assign entry_state = (state_q == ST_OP1) | (state_q == ST_OP2);

  // ---------------------------------------------------------------------------
  // State register (also holds every registered output)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_OP1;
      key_ready_q    <= 1'b1;
      is_num_q       <= 1'b0;
      num_val_q      <= 4'd0;
      is_op1_q       <= 1'b1;
      is_op2_q       <= 1'b0;
      op_val_q       <= KEY_ADD;
      op_clr_q       <= 1'b0;
      digit_cnt_q    <= 3'd0;
      disp_sel_q     <= 2'b00;
      result_valid_q <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      key_ready_q    <= key_ready_d;
      is_num_q       <= is_num_d;
      num_val_q      <= num_val_d;
      is_op1_q       <= is_op1_d;
      is_op2_q       <= is_op2_d;
      op_val_q       <= op_val_d;
      op_clr_q       <= op_clr_d;
      digit_cnt_q    <= digit_cnt_d;
      disp_sel_q     <= disp_sel_d;
      result_valid_q <= result_valid_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OP1: begin
        if (key_arith) state_d = ST_OP2;
      end
      ST_OP2: begin
        if (key_clr)     state_d = ST_OP1;
        else if (key_eq) state_d = ST_CALC;
      end
      ST_CALC: begin
        // Leaving when the counter would reach zero keeps CALC exactly
        // ALU_LAT cycles long.
        if (wait_cnt_q <= WAIT_W'(1)) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (key_clr) state_d = ST_OP1;
      end
      default: state_d = ST_OP1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs. Level outputs follow
  // the state being entered so they line up with the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    is_op1_d       = (state_d == ST_OP1);
    is_op2_d       = (state_d == ST_OP2);
    key_ready_d    = (state_d != ST_CALC);
    result_valid_d = (state_d == ST_SHOW);
    case (state_d)
      ST_OP1:  disp_sel_d = 2'b00;
      ST_SHOW: disp_sel_d = 2'b10;
      default: disp_sel_d = 2'b01;
    endcase

    is_num_d    = 1'b0;
    num_val_d   = num_val_q;
    op_val_d    = op_val_q;
    op_clr_d    = 1'b0;
    digit_cnt_d = digit_cnt_q;
    wait_cnt_d  = wait_cnt_q;

    if (entry_state && key_digit && (digit_cnt_q < 3'(MAX_DIGITS))) begin
      is_num_d    = 1'b1;
      num_val_d   = key_code;
      digit_cnt_d = digit_cnt_q + 3'd1;
    end

    if (entry_state && key_arith) begin
      op_val_d = key_code;
      // A fresh operand starts only on the first operator; later operator
      // keys in OP2 just replace the operation.
      if (state_q == ST_OP1) digit_cnt_d = 3'd0;
    end

    if (key_clr) begin
      op_clr_d    = 1'b1;
      digit_cnt_d = 3'd0;
      op_val_d    = KEY_ADD;
    end

    if ((state_q == ST_OP2) && key_eq) wait_cnt_d = WAIT_W'(ALU_LAT);

    if ((state_q == ST_CALC) && (wait_cnt_q != '0)) wait_cnt_d = wait_cnt_q - WAIT_W'(1);
  end

  assign key_ready    = key_ready_q;
  assign is_num       = is_num_q;
  assign num_val      = num_val_q;
  assign is_op1       = is_op1_q;
  assign is_op2       = is_op2_q;
  assign op_val       = op_val_q;
  assign op_clr       = op_clr_q;
  assign digit_cnt    = digit_cnt_q;
  assign disp_sel     = disp_sel_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_key_sequencer
//   Directed self-checking bench for calc_key_sequencer (MAX_DIGITS=4,
//   ALU_LAT=2). Keys are driven at the falling edge, outputs sampled 1 ns
//   after the rising edge that accepts them.
// -----------------------------------------------------------------------------
module tb_calc_key_sequencer;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       is_num;
  logic [3:0] num_val;
  logic       is_op1;
  logic       is_op2;
  logic [3:0] op_val;
  logic       op_clr;
  logic [2:0] digit_cnt;
  logic [1:0] disp_sel;
  logic       result_valid;

  int checks_cnt;
  int errors_cnt;

  calc_key_sequencer #(
    .MAX_DIGITS(4),
    .ALU_LAT   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .is_num      (is_num),
    .num_val     (num_val),
    .is_op1      (is_op1),
    .is_op2      (is_op2),
    .op_val      (op_val),
    .op_clr      (op_clr),
    .digit_cnt   (digit_cnt),
    .disp_sel    (disp_sel),
    .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One key strobe; returns just after the edge that would accept it.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    $display("key %h: rdy=%0b num=%0b/%h op1=%0b op2=%0b op=%h clr=%0b cnt=%0d disp=%0d rv=%0b",
             code, key_ready, is_num, num_val, is_op1, is_op2, op_val, op_clr,
             digit_cnt, disp_sel, result_valid);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_key_ready"}, key_ready, 1);
    check({tag, "_is_num"}, is_num, 0);
    check({tag, "_num_val"}, num_val, 0);
    check({tag, "_is_op1"}, is_op1, 1);
    check({tag, "_is_op2"}, is_op2, 0);
    check({tag, "_op_val"}, op_val, 4'hD);
    check({tag, "_op_clr"}, op_clr, 0);
    check({tag, "_digit_cnt"}, digit_cnt, 0);
    check({tag, "_disp_sel"}, disp_sel, 0);
    check({tag, "_result_valid"}, result_valid, 0);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n      = 1'b0;
    key_valid  = 1'b0;
    key_code   = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Five digits back to back: four stored, fifth dropped.
    for (int k = 1; k <= 4; k++) begin
      press(4'(k));
      check("dig_is_num", is_num, 1);
      check("dig_num_val", num_val, k);
      check("dig_cnt", digit_cnt, k);
      check("dig_is_op1", is_op1, 1);
    end
    press(4'h5);
    check("dig5_is_num", is_num, 0);
    check("dig5_cnt", digit_cnt, 4);
    check("dig5_num_val", num_val, 4);

    // 7 dropped, '+' moves to OP2, '-' replaces op, 3 stored under op2.
    press(4'h7);
    check("d7_is_num", is_num, 0);
    press(4'hD);
    check("add_is_op2", is_op2, 1);
    check("add_is_op1", is_op1, 0);
    check("add_op_val", op_val, 4'hD);
    check("add_cnt", digit_cnt, 0);
    check("add_disp", disp_sel, 1);
    check("add_is_num", is_num, 0);
    press(4'hE);
    check("sub_op_val", op_val, 4'hE);
    check("sub_is_op2", is_op2, 1);
    press(4'h3);
    check("op2_is_num", is_num, 1);
    check("op2_num_val", num_val, 3);
    check("op2_is_op2", is_op2, 1);
    check("op2_cnt", digit_cnt, 1);

    // Ignored code.
    press(4'hA);
    check("ign_is_num", is_num, 0);
    check("ign_cnt", digit_cnt, 1);
    check("ign_op_val", op_val, 4'hE);

    // '=' -> two busy cycles, result in the third.
    press(4'hF);
    check("eq1_key_ready", key_ready, 0);
    check("eq1_is_op2", is_op2, 0);
    check("eq1_is_op1", is_op1, 0);
    check("eq1_disp", disp_sel, 1);
    check("eq1_rv", result_valid, 0);
    press(4'h5);  // dropped while busy
    check("eq2_key_ready", key_ready, 0);
    check("eq2_is_num", is_num, 0);
    check("eq2_rv", result_valid, 0);
    check("eq2_cnt", digit_cnt, 1);
    check("eq2_num_val", num_val, 3);
    idle();
    check("eq3_rv", result_valid, 1);
    check("eq3_disp", disp_sel, 2);
    check("eq3_key_ready", key_ready, 1);

    // SHOW ignores digits and equals.
    press(4'h9);
    check("show_is_num", is_num, 0);
    check("show_rv", result_valid, 1);
    press(4'hF);
    check("show_eq_rv", result_valid, 1);
    check("show_eq_disp", disp_sel, 2);

    // Clear from SHOW.
    press(4'hC);
    check("clr_op_clr", op_clr, 1);
    check("clr_rv", result_valid, 0);
    check("clr_is_op1", is_op1, 1);
    check("clr_op_val", op_val, 4'hD);
    check("clr_cnt", digit_cnt, 0);
    check("clr_is_num", is_num, 0);
    check("clr_disp", disp_sel, 0);
    idle();
    check("clr_pulse_end", op_clr, 0);

    // '=' in OP1 ignored.
    press(4'hF);
    check("op1eq_is_op1", is_op1, 1);
    check("op1eq_key_ready", key_ready, 1);
    check("op1eq_rv", result_valid, 0);

    // Clear in OP1 after one digit.
    press(4'h2);
    check("op1d_cnt", digit_cnt, 1);
    press(4'hC);
    check("op1clr_op_clr", op_clr, 1);
    check("op1clr_cnt", digit_cnt, 0);
    check("op1clr_is_num", is_num, 0);

    // Empty op1, '-', '=' -> CALC, then async reset mid-CALC.
    press(4'hE);
    check("e_is_op2", is_op2, 1);
    press(4'hF);
    check("calc_key_ready", key_ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    #2;
    rst_n = 1'b1;
    idle();
    check("post_rst_is_op1", is_op1, 1);
    check("post_rst_rv", result_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
